bus_cycle_ctrl: RTL

- Sequences every 68010 bus cycle: qualifies address strobe, picks region wait-state count, drives DTACK/VPA/BERR terminations.
- Sits between the external address decoder and the CPU termination pins, which are shared open-drain with other sources.
- Owns the bus-timeout function for unterminated cycles: unmapped addresses, or IO devices that never become ready.

---
 rtl/bus_cycle_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bus_cycle_ctrl.sv
// 68010 bus cycle controller: region wait states, DTACK/VPA/BERR termination, optional bus timeout.
// Define BUS_TIMEOUT_EN to build the timeout counter and the sticky o_TIMEOUT flag.
//
// state  | meaning
// IDLE   | no cycle in progress, waiting for address strobe
// WAIT   | counting region wait states
// IOWAIT | IO wait states done, waiting for device ready
// ACK    | DTACK (or VPA for IACK) just asserted
// FAULT  | bad decode or timeout, BERR asserts on the next edge
// END    | termination held until the strobe is released
module bus_cycle_ctrl #(
  parameter int unsigned ROM_WAIT = 2,
  parameter int unsigned RAM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 4,
  parameter int unsigned TIMEOUT  = 127
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_AS_n,
  input  logic [2:0] i_FC,
  input  logic       i_ROM_SEL,
  input  logic       i_RAM_SEL,
  input  logic       i_IO_SEL,
  input  logic       i_IO_READY,
  input  logic       i_TO_CLR,
  output logic       o_DTACK_n,
  output logic       o_VPA_n,
  output logic       o_BERR_n,
  output logic       o_BUSY,
  output logic       o_TIMEOUT
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_IOWAIT, ST_ACK, ST_FAULT, ST_END
  } state_t;

  typedef enum logic [1:0] {
    CY_MEM, CY_IO, CY_IACK, CY_NONE
  } cyc_t;

  localparam logic [7:0] ROM_W8 = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_W8 = 8'(RAM_WAIT);
  localparam logic [7:0] IO_W8  = 8'(IO_WAIT);
  localparam logic [7:0] TO8    = 8'(TIMEOUT);

  state_t     state;
  cyc_t       cyc;
  logic [7:0] wcnt;
  logic       dtack;
  logic       vpa;
  logic       berr;

  logic       is_iack;
  logic [1:0] sel_cnt;
  logic       multi_sel;
  logic [7:0] wait_load;
  cyc_t       cyc_load;
  logic       in_wait;
  logic       to_hit;

  // Decode used only at the strobe edge; IACK overrides every region select.
  always_comb begin
    is_iack   = (i_FC == 3'b111);
    sel_cnt   = {1'b0, i_ROM_SEL} + {1'b0, i_RAM_SEL} + {1'b0, i_IO_SEL};
    multi_sel = !is_iack && (sel_cnt > 2'd1);
    wait_load = 8'd0;
    cyc_load  = CY_NONE;
    if (is_iack) begin
      cyc_load = CY_IACK;
    end else if (i_ROM_SEL) begin
      cyc_load  = CY_MEM;
      wait_load = ROM_W8;
    end else if (i_RAM_SEL) begin
      cyc_load  = CY_MEM;
      wait_load = RAM_W8;
    end else if (i_IO_SEL) begin
      cyc_load  = CY_IO;
      wait_load = IO_W8;
    end
  end

  assign in_wait = (state == ST_WAIT) || (state == ST_IOWAIT);

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       timeout_flag;
  logic       timeout_fire;

  assign to_hit       = (tcnt == TO8);
  assign timeout_fire = in_wait && !i_AS_n && to_hit;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      tcnt <= 8'd0;
    end else if (state == ST_IDLE) begin
      tcnt <= 8'd0;
    end else if (in_wait) begin
      tcnt <= tcnt + 8'd1;
    end
  end

  // A new timeout on the same edge as a clear request keeps the flag set.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      timeout_flag <= 1'b0;
    end else if (timeout_fire) begin
      timeout_flag <= 1'b1;
    end else if (i_TO_CLR) begin
      timeout_flag <= 1'b0;
    end
  end

  assign o_TIMEOUT = timeout_flag;
`else
  logic unused_timeout;

  assign to_hit         = 1'b0;
  assign o_TIMEOUT      = 1'b0;
  assign unused_timeout = ^{i_TO_CLR, TO8};
`endif

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state <= ST_IDLE;
      cyc   <= CY_NONE;
      wcnt  <= 8'd0;
      dtack <= 1'b0;
      vpa   <= 1'b0;
      berr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!i_AS_n) begin
            wcnt  <= wait_load;
            cyc   <= cyc_load;
            state <= multi_sel ? ST_FAULT : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_AS_n) begin
            state <= ST_IDLE;
          end else if (to_hit) begin
            state <= ST_FAULT;
          end else if (wcnt != 8'd0) begin
            wcnt <= wcnt - 8'd1;
          end else begin
            case (cyc)
              CY_MEM: begin
                state <= ST_ACK;
                dtack <= 1'b1;
              end
              CY_IACK: begin
                state <= ST_ACK;
                vpa   <= 1'b1;
              end
              CY_IO: begin
                // A device already ready when the minimum wait expires is acked without an IOWAIT pass.
                if (i_IO_READY) begin
                  state <= ST_ACK;
                  dtack <= 1'b1;
                end else begin
                  state <= ST_IOWAIT;
                end
              end
              default: state <= ST_WAIT;
            endcase
          end
        end
        ST_IOWAIT: begin
          if (i_AS_n) begin
            state <= ST_IDLE;
          end else if (to_hit) begin
            state <= ST_FAULT;
          end else if (i_IO_READY) begin
            state <= ST_ACK;
            dtack <= 1'b1;
          end
        end
        ST_ACK: begin
          state <= ST_END;
        end
        ST_FAULT: begin
          berr  <= 1'b1;
          state <= ST_END;
        end
        ST_END: begin
          if (i_AS_n) begin
            dtack <= 1'b0;
            vpa   <= 1'b0;
            berr  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Terminations are open-drain: pull low or float.
  assign o_DTACK_n = dtack ? 1'b0 : 1'bz;
  assign o_VPA_n   = vpa   ? 1'b0 : 1'bz;
  assign o_BERR_n  = berr  ? 1'b0 : 1'bz;
  assign o_BUSY    = (state != ST_IDLE);

endmodule
